// File: rtl/bird_sprite_painter.sv
// Two-stage bird sprite painter: per-frame position latch, disc body with animated wing,
// and a per-frame bird/pipe collision flag.
module bird_sprite_painter #(
    parameter int CW          = 11,
    parameter int RADIUS      = 32,
    parameter int FLAP_FRAMES = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [CW-1:0] bx,
    input  logic [CW-1:0] by,
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    input  logic          pix_valid,
    input  logic          pipe_hit_in,
    output logic          pix_valid_out,
    output logic          bird_pix,
    output logic          wing_pix,
    output logic          flap_phase,
    output logic          collision
);

    localparam int SW    = 2 * CW + 3;
    localparam int CNT_W = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;

    localparam logic [SW-1:0]    R_SQ   = SW'(RADIUS * RADIUS);
    localparam logic signed [CW:0] NEG_R  = (CW + 1)'(-RADIUS);
    localparam logic signed [CW:0] NEG_R4 = (CW + 1)'(-(RADIUS / 4));
    localparam logic signed [CW:0] NEG_R2 = (CW + 1)'(-(RADIUS / 2));
    localparam logic signed [CW:0] POS_R2 = (CW + 1)'(RADIUS / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLAP_FRAMES - 1);

    logic [CW-1:0]       bx_l_q, bx_l_d, by_l_q, by_l_d;
    logic signed [CW:0]  dx_q, dx_d, dy_q, dy_d;
    logic                valid1_q, valid1_d, hit1_q, hit1_d;
    logic                pv_out_q, pv_out_d, bird_q, bird_d, wing_q, wing_d;
    logic                flap_q, flap_d, coll_q, coll_d, acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic signed [2*CW+1:0] dx_sq, dy_sq;
    logic [SW-1:0]          sum;
    logic                   body, wing, dy_rng, hit;

    always_comb begin
        bx_l_d   = bx_l_q;
        by_l_d   = by_l_q;
        cnt_d    = cnt_q;
        flap_d   = flap_q;
        coll_d   = coll_q;

        // Zero-extend before subtracting so offsets never wrap
        dx_d     = $signed({1'b0, px}) - $signed({1'b0, bx_l_q});
        dy_d     = $signed({1'b0, py}) - $signed({1'b0, by_l_q});
        valid1_d = pix_valid;
        hit1_d   = pipe_hit_in;

        dx_sq  = dx_q * dx_q;
        dy_sq  = dy_q * dy_q;
        sum    = {1'b0, dx_sq} + {1'b0, dy_sq};
        body   = valid1_q && (sum < R_SQ);
        dy_rng = flap_q ? (!dy_q[CW] && (dy_q < POS_R2))
                        : (dy_q[CW] && (dy_q >= NEG_R2));
        wing   = body && (dx_q >= NEG_R) && (dx_q <= NEG_R4) && dy_rng;
        hit    = body && hit1_q;

        pv_out_d = valid1_q;
        bird_d   = body;
        wing_d   = wing;

        if (frame_start) begin
            bx_l_d = bx;
            by_l_d = by;
            // A hit resolving on the frame boundary still belongs to the closing frame
            coll_d = acc_q | hit;
            acc_d  = 1'b0;
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                flap_d = !flap_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            acc_d = acc_q | hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bx_l_q   <= '0;
            by_l_q   <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            valid1_q <= 1'b0;
            hit1_q   <= 1'b0;
            pv_out_q <= 1'b0;
            bird_q   <= 1'b0;
            wing_q   <= 1'b0;
            flap_q   <= 1'b0;
            coll_q   <= 1'b0;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bx_l_q   <= bx_l_d;
            by_l_q   <= by_l_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            valid1_q <= valid1_d;
            hit1_q   <= hit1_d;
            pv_out_q <= pv_out_d;
            bird_q   <= bird_d;
            wing_q   <= wing_d;
            flap_q   <= flap_d;
            coll_q   <= coll_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pix_valid_out = pv_out_q;
    assign bird_pix      = bird_q;
    assign wing_pix      = wing_q;
    assign flap_phase    = flap_q;
    assign collision     = coll_q;

endmodule
